// File: rtl/transmite_bcd_ascii_n_if.sv
// Bus bundle for transmite_bcd_ascii_n: BCD word, start request, status flags and UART line.
// The master drives the request side; the slave (the transmitter) drives status and tx_serial.
interface transmite_bcd_ascii_n_if #(
    parameter int unsigned NUM_DIGITS = 2
) ();

    logic [4*NUM_DIGITS-1:0] bcd;
    logic                    transmite_bcd;
    logic                    pronto;
    logic                    ocupado;
    logic                    tx_serial;

    modport master (
        output bcd,
        output transmite_bcd,
        input  pronto,
        input  ocupado,
        input  tx_serial
    );

    modport slave (
        input  bcd,
        input  transmite_bcd,
        output pronto,
        output ocupado,
        output tx_serial
    );

endinterface

// File: rtl/transmite_bcd_ascii_n.sv
// N-digit packed BCD to ASCII serial transmitter (8N1), most-significant digit first.
// Optional CR/LF terminator after the last digit when TRANSMITE_BCD_TERMINADOR_EN is defined.
module transmite_bcd_ascii_n #(
    parameter int unsigned NUM_DIGITS   = 2,
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic                    clock,
    input  logic                    reset,
    transmite_bcd_ascii_n_if.slave  bus
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW  = $clog2(NUM_DIGITS + 2);
    localparam int unsigned BcdW  = 4 * NUM_DIGITS;
`ifdef TRANSMITE_BCD_TERMINADOR_EN
    localparam int unsigned NumChars = NUM_DIGITS + 2;
`else
    localparam int unsigned NumChars = NUM_DIGITS;
`endif

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BaudW-1:0] BaudOne  = BaudW'(1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NumChars - 1);
    localparam logic [IdxW-1:0]  IdxOne   = IdxW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StNext,
        StDone
    } state_e;

    state_e            state_q;
    logic [BaudW-1:0]  baud_q;
    logic [2:0]        bit_q;
    logic [IdxW-1:0]   idx_q;
    logic [BcdW-1:0]   shift_q;
    logic              tx_q;
    logic              pronto_q;
    logic              ocupado_q;

    logic [3:0]        digit;
    logic [7:0]        char_digit;
    logic [7:0]        char_cur;
    logic              baud_last;

    // The current digit always sits in the top nibble; the register shifts left after each character.
    always_comb begin
        digit      = shift_q[BcdW-1 -: 4];
        char_digit = (digit <= 4'd9) ? (8'h30 + {4'h0, digit}) : 8'h3F;
`ifdef TRANSMITE_BCD_TERMINADOR_EN
        if (idx_q < IdxW'(NUM_DIGITS)) begin
            char_cur = char_digit;
        end else if (idx_q == IdxW'(NUM_DIGITS)) begin
            char_cur = 8'h0D;
        end else begin
            char_cur = 8'h0A;
        end
`else
        char_cur = char_digit;
`endif
        baud_last = (baud_q == BaudLast);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.transmite_bcd) begin
                        shift_q   <= bus.bcd;
                        idx_q     <= '0;
                        baud_q    <= '0;
                        bit_q     <= '0;
                        ocupado_q <= 1'b1;
                        tx_q      <= 1'b0;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= char_cur[0];
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + BaudOne;
                    end
                end
                StData: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= char_cur[bit_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + BaudOne;
                    end
                end
                StStop: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= StNext;
                    end else begin
                        baud_q <= baud_q + BaudOne;
                    end
                end
                // One idle-high cycle between characters, or the end of the message.
                StNext: begin
                    if (idx_q == IdxLast) begin
                        pronto_q  <= 1'b1;
                        ocupado_q <= 1'b0;
                        state_q   <= StDone;
                    end else begin
                        idx_q   <= idx_q + IdxOne;
                        shift_q <= shift_q << 4;
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.tx_serial = tx_q;
    assign bus.pronto    = pronto_q;
    assign bus.ocupado   = ocupado_q;

endmodule

// File: tb/tb_transmite_bcd_ascii_n.sv
// Self-checking bench for transmite_bcd_ascii_n: 2-digit and 4-digit instances, CLKS_PER_BIT=4.
// Expected line waveform is built from the framing rules; characters are also decoded from the line.
module tb_transmite_bcd_ascii_n;

    localparam int Cpb      = 4;
    localparam int FrameLen = 10 * Cpb;
    localparam int CharLen  = FrameLen + 1;
`ifdef TRANSMITE_BCD_TERMINADOR_EN
    localparam int ExtraChars = 2;
`else
    localparam int ExtraChars = 0;
`endif

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    transmite_bcd_ascii_n_if #(.NUM_DIGITS(2)) b2 ();
    transmite_bcd_ascii_n_if #(.NUM_DIGITS(4)) b4 ();

    transmite_bcd_ascii_n #(.NUM_DIGITS(2), .CLKS_PER_BIT(Cpb)) u_dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (b2)
    );

    transmite_bcd_ascii_n #(.NUM_DIGITS(4), .CLKS_PER_BIT(Cpb)) u_dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (b4)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          w;
        logic [31:0] bcd;
        logic [31:0] exp_chars;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] enc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

    function automatic logic [31:0] model_digits(input logic [31:0] v, input int nd);
        logic [31:0] r;
        r = '0;
        for (int i = nd - 1; i >= 0; i--) r = (r << 8) | {24'h0, enc(v[4*i +: 4])};
        return r;
    endfunction

    function automatic logic get_tx(input int w);
        return (w != 0) ? b4.tx_serial : b2.tx_serial;
    endfunction

    function automatic logic get_oc(input int w);
        return (w != 0) ? b4.ocupado : b2.ocupado;
    endfunction

    function automatic logic get_pr(input int w);
        return (w != 0) ? b4.pronto : b2.pronto;
    endfunction

    task automatic drive(input int w, input logic [31:0] v, input logic req);
        if (w != 0) begin
            b4.bcd           = v[15:0];
            b4.transmite_bcd = req;
        end else begin
            b2.bcd           = v[7:0];
            b2.transmite_bcd = req;
        end
    endtask

    // Called at a negedge; requests for one cycle and follows the whole message cycle by cycle.
    task automatic run_msg(input int w, input logic [31:0] v, input logic [31:0] exp_digits,
                           input int poke, input logic [31:0] poke_v);
        int          nd;
        int          nch;
        int          len;
        int          c;
        int          r;
        int          p;
        int          i;
        logic        e_tx;
        logic        e_oc;
        logic        e_pr;
        logic [31:0] md;
        logic [7:0]  ch;
        logic [7:0]  mch [$];
        logic [7:0]  tch [$];
        logic [7:0]  dec [$];
        logic        smp [$];

        nd  = (w != 0) ? 4 : 2;
        nch = nd + ExtraChars;
        len = nch * CharLen;
        md  = model_digits(v, nd);
        for (int j = nd - 1; j >= 0; j--) begin
            mch.push_back(md[8*j +: 8]);
            tch.push_back(exp_digits[8*j +: 8]);
        end
        if (ExtraChars != 0) begin
            mch.push_back(8'h0D);
            mch.push_back(8'h0A);
            tch.push_back(8'h0D);
            tch.push_back(8'h0A);
        end

        drive(w, v, 1'b1);
        @(negedge clock);
        drive(w, v, 1'b0);
        for (int k = 0; k < len + 4; k++) begin
            if (k < len) begin
                c = k / CharLen;
                r = k % CharLen;
                if (r == FrameLen) begin
                    e_tx = 1'b1;
                end else begin
                    p = r / Cpb;
                    if (p == 0) e_tx = 1'b0;
                    else if (p == 9) e_tx = 1'b1;
                    else e_tx = mch[c][p-1];
                end
                e_oc = 1'b1;
                e_pr = 1'b0;
                smp.push_back(get_tx(w));
            end else begin
                e_tx = 1'b1;
                e_oc = 1'b0;
                e_pr = (k == len);
            end
            check($sformatf("w%0d k%0d tx_serial", w, k), {31'h0, get_tx(w)}, {31'h0, e_tx});
            check($sformatf("w%0d k%0d ocupado", w, k), {31'h0, get_oc(w)}, {31'h0, e_oc});
            check($sformatf("w%0d k%0d pronto", w, k), {31'h0, get_pr(w)}, {31'h0, e_pr});
            if (poke >= 0 && k == poke) drive(w, poke_v, 1'b1);
            else if (poke >= 0 && k == poke + 1) drive(w, poke_v, 1'b0);
            @(negedge clock);
        end

        // Independent UART decode of the sampled line, sampling mid-bit.
        i = 0;
        while (i + FrameLen <= smp.size()) begin
            if (smp[i] == 1'b0) begin
                for (int b = 0; b < 8; b++) ch[b] = smp[i + Cpb * (b + 1) + Cpb / 2];
                check($sformatf("w%0d stop bit char %0d", w, dec.size()),
                      {31'h0, smp[i + 9 * Cpb + Cpb / 2]}, 32'h1);
                dec.push_back(ch);
                i += FrameLen;
            end else begin
                i++;
            end
        end
        check($sformatf("w%0d decoded char count", w), dec.size(), tch.size());
        for (int j = 0; j < dec.size() && j < tch.size(); j++)
            check($sformatf("w%0d decoded char %0d", w, j), {24'h0, dec[j]}, {24'h0, tch[j]});
    endtask

    initial begin
        vecs[0] = '{w: 0, bcd: 32'h47,   exp_chars: 32'h3437};
        vecs[1] = '{w: 1, bcd: 32'h1A09, exp_chars: 32'h313F3039};
        vecs[2] = '{w: 0, bcd: 32'h05,   exp_chars: 32'h3035};
        vecs[3] = '{w: 0, bcd: 32'hF0,   exp_chars: 32'h3F30};
        vecs[4] = '{w: 1, bcd: 32'h9876, exp_chars: 32'h39383736};

        // Reset held with requests asserted: line idle, no status.
        reset = 1'b0;
        drive(0, 32'h47, 1'b1);
        drive(1, 32'h1234, 1'b1);
        repeat (3) begin
            @(negedge clock);
            for (int w = 0; w < 2; w++) begin
                check($sformatf("reset w%0d tx_serial", w), {31'h0, get_tx(w)}, 32'h1);
                check($sformatf("reset w%0d ocupado", w), {31'h0, get_oc(w)}, 32'h0);
                check($sformatf("reset w%0d pronto", w), {31'h0, get_pr(w)}, 32'h0);
            end
        end
        drive(1, 32'h1234, 1'b0);
        reset = 1'b1;
        run_msg(0, 32'h47, 32'h3437, -1, 32'h0);

        for (int n = 0; n < 5; n++) run_msg(vecs[n].w, vecs[n].bcd, vecs[n].exp_chars, -1, 32'h0);

        // Request and bcd change while busy must be ignored.
        run_msg(0, 32'h12, 32'h3132, 10, 32'h99);
        repeat (20) begin
            check("busy no second message ocupado", {31'h0, get_oc(0)}, 32'h0);
            check("busy no second message tx", {31'h0, get_tx(0)}, 32'h1);
            @(negedge clock);
        end

        // Reset during data bits of the second character.
        drive(0, 32'h56, 1'b1);
        @(negedge clock);
        drive(0, 32'h56, 1'b0);
        repeat (53) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midreset tx_serial", {31'h0, get_tx(0)}, 32'h1);
        check("midreset ocupado", {31'h0, get_oc(0)}, 32'h0);
        check("midreset pronto", {31'h0, get_pr(0)}, 32'h0);
        @(negedge clock);
        check("midreset hold pronto", {31'h0, get_pr(0)}, 32'h0);
        reset = 1'b1;
        run_msg(0, 32'h83, 32'h3833, -1, 32'h0);

        repeat (6) begin
            int          w;
            logic [31:0] v;
            w = int'($urandom_range(0, 1));
            v = $urandom;
            v = (w != 0) ? (v & 32'hFFFF) : (v & 32'hFF);
            run_msg(w, v, model_digits(v, (w != 0) ? 4 : 2), -1, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
